// File: rtl/risc8_timer_multi.sv
// risc8 multi-channel timer: prescaled 8/16-bit counter, compare channels,
// CTC, write-1-to-clear flags, maskable irq and TEMP-latched 16-bit access.
module risc8_timer_multi #(
    parameter logic [6:0] BASE     = 7'h4C,
    parameter int         WIDTH    = 16,
    parameter int         CHANNELS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ren,
    input  logic                wen,
    input  logic [6:0]          addr,
    input  logic [7:0]          wdata,
    output logic [7:0]          rdata,
    output logic                valid,
    output logic                irq,
    output logic [CHANNELS-1:0] ocm
);
    localparam int         NF   = CHANNELS + 1;
    localparam logic [6:0] NREG = 7'(5 + 2 * CHANNELS);
    localparam bit         WIDE = (WIDTH == 16);

    logic [3:0]          tccr_q, tccr_d;
    logic [NF-1:0]       tifr_q, tifr_d;
    logic [NF-1:0]       timsk_q, timsk_d;
    logic [WIDTH-1:0]    tcnt_q, tcnt_d;
    logic [WIDTH-1:0]    ocr_q [CHANNELS];
    logic [WIDTH-1:0]    ocr_d [CHANNELS];
    logic [7:0]          temp_q, temp_d;
    logic [7:0]          rdata_q, rdata_d;
    logic [9:0]          presc_q, presc_d;
    logic                valid_q, valid_d;
    logic [CHANNELS-1:0] ocm_q, ocm_d;

    logic [6:0]          off;
    logic                hit, rd, wr, tick;
    logic [15:0]         tcnt16, ocr16, wide_val;
    logic [NF-1:0]       set, clr;
    logic [CHANNELS-1:0] match;

    always_comb begin
        off      = addr - BASE;
        hit      = (addr >= BASE) && (off < NREG);
        rd       = ren && hit;
        wr       = wen && hit;
        tcnt16   = 16'(tcnt_q);
        wide_val = WIDE ? {temp_q, wdata} : {8'h00, wdata};
        unique case (tccr_q[2:0])
            3'd1:    tick = 1'b1;
            3'd2:    tick = &presc_q[2:0];
            3'd3:    tick = &presc_q[5:0];
            3'd4:    tick = &presc_q[7:0];
            3'd5:    tick = &presc_q;
            default: tick = 1'b0;
        endcase
    end

    always_comb begin
        tccr_d  = tccr_q;
        timsk_d = timsk_q;
        tcnt_d  = tcnt_q;
        ocr_d   = ocr_q;
        temp_d  = temp_q;
        presc_d = presc_q;
        rdata_d = rdata_q;
        valid_d = rd;
        ocm_d   = '0;
        set     = '0;
        clr     = '0;
        ocr16   = '0;
        match   = '0;

        if (tccr_q[2:0] != 3'd0)
            presc_d = presc_q + 10'd1;
        if (wr && off == 7'd0) begin
            tccr_d  = wdata[3:0];
            presc_d = '0;
        end
        if (wr && off == 7'd1)
            clr = wdata[NF-1:0];
        if (wr && off == 7'd2)
            timsk_d = wdata[NF-1:0];

        for (int i = 0; i < CHANNELS; i++)
            match[i] = (tcnt_q == ocr_q[i]);

        // a CPU commit suppresses the whole tick: no count, compare or OVF
        if (wr && off == 7'd3) begin
            tcnt_d = wide_val[WIDTH-1:0];
        end else if (tick) begin
            ocm_d = match;
            set[NF-1:1] = match;
            if (tccr_q[3] && match[0]) begin
                tcnt_d = '0;
            end else if (&tcnt_q) begin
                tcnt_d = '0;
                set[0] = 1'b1;
            end else begin
                tcnt_d = tcnt_q + WIDTH'(1);
            end
        end
        tifr_d = (tifr_q & ~clr) | set;

        if (rd) begin
            if (off == 7'd0)
                rdata_d = {4'h0, tccr_q};
            else if (off == 7'd1)
                rdata_d = 8'(tifr_q);
            else if (off == 7'd2)
                rdata_d = 8'(timsk_q);
            else if (off == 7'd3) begin
                rdata_d = tcnt16[7:0];
                if (WIDE)
                    temp_d = tcnt16[15:8];
            end else if (off == 7'd4)
                rdata_d = WIDE ? temp_q : 8'h00;
        end

        for (int i = 0; i < CHANNELS; i++) begin
            ocr16 = 16'(ocr_q[i]);
            if (rd && off == 7'(5 + 2 * i)) begin
                rdata_d = ocr16[7:0];
                if (WIDE)
                    temp_d = ocr16[15:8];
            end
            if (rd && off == 7'(6 + 2 * i))
                rdata_d = WIDE ? temp_q : 8'h00;
            if (wr && off == 7'(5 + 2 * i))
                ocr_d[i] = wide_val[WIDTH-1:0];
        end

        // high-byte writes land in TEMP; they override a same-cycle latch
        if (WIDE && wr && off >= 7'd4 && !off[0])
            temp_d = wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tccr_q  <= '0;
            tifr_q  <= '0;
            timsk_q <= '0;
            tcnt_q  <= '0;
            temp_q  <= '0;
            presc_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            ocm_q   <= '0;
            for (int i = 0; i < CHANNELS; i++)
                ocr_q[i] <= '1;
        end else begin
            tccr_q  <= tccr_d;
            tifr_q  <= tifr_d;
            timsk_q <= timsk_d;
            tcnt_q  <= tcnt_d;
            temp_q  <= temp_d;
            presc_q <= presc_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            ocm_q   <= ocm_d;
            for (int i = 0; i < CHANNELS; i++)
                ocr_q[i] <= ocr_d[i];
        end
    end

    assign rdata = rdata_q;
    assign valid = valid_q;
    assign ocm   = ocm_q;
    assign irq   = |(tifr_q & timsk_q);

endmodule
